// File: rtl/psum_drain_pkg.sv
// Shared constants and FSM encoding for the systolic-array control blocks.
package psum_drain_pkg;

  localparam int PD_NUM_ROWS        = 32;
  localparam int PD_NUM_ROWS_LOG2   = 5;
  localparam int PD_NUM_COLS        = 32;
  localparam int PD_NUM_COLS_LOG2   = 5;
  localparam int PD_DWIDTH          = 32;
  localparam int PD_OUT_SRAM_AWIDTH = 10;
  localparam int PD_MAX_TILE_LOG2   = 5;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_WAIT_WR = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/psum_drain_col.sv
// Zeroes every column at or beyond the active column count.
module col_mask
  import psum_drain_pkg::*;
#(
  parameter int NUM_COLS      = PD_NUM_COLS,
  parameter int NUM_COLS_LOG2 = PD_NUM_COLS_LOG2,
  parameter int DWIDTH        = PD_DWIDTH
) (
  input  logic [NUM_COLS*DWIDTH-1:0] data,
  input  logic [NUM_COLS_LOG2:0]     count,
  output logic [NUM_COLS*DWIDTH-1:0] masked
);

  localparam int CW = NUM_COLS_LOG2 + 1;

  always_comb begin
    masked = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (CW'(c) < count) masked[c*DWIDTH +: DWIDTH] = data[c*DWIDTH +: DWIDTH];
    end
  end

endmodule

// File: rtl/psum_drain.sv
// Drains one tile of partial sums from the PE array into the output SRAM,
// one row per shift, through a single-entry output register.
//
// state      | meaning
// IDLE       | waiting for START_in, config latched on start
// DRAIN      | shifting NUM_ROWS rows out of the array, writing active ones
// WAIT_WR    | all rows shifted, waiting for the last write to be accepted
// DONE       | one-cycle completion pulse
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int NUM_ROWS        = PD_NUM_ROWS,
  parameter int NUM_ROWS_LOG2   = PD_NUM_ROWS_LOG2,
  parameter int NUM_COLS        = PD_NUM_COLS,
  parameter int NUM_COLS_LOG2   = PD_NUM_COLS_LOG2,
  parameter int DWIDTH          = PD_DWIDTH,
  parameter int OUT_SRAM_AWIDTH = PD_OUT_SRAM_AWIDTH,
  parameter int MAX_TILE_LOG2   = PD_MAX_TILE_LOG2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START_in,
  input  logic [MAX_TILE_LOG2-1:0]     TILE_ROW_ID_in,
  input  logic [MAX_TILE_LOG2-1:0]     TILE_COL_ID_in,
  input  logic [MAX_TILE_LOG2:0]       NUM_TILE_COLS_in,
  input  logic [NUM_ROWS_LOG2:0]       ACTV_ROWS_in,
  input  logic [NUM_COLS_LOG2:0]       ACTV_COLS_in,
  input  logic [NUM_COLS*DWIDTH-1:0]   PE_ROW_DATA_in,
  output logic                         PE_SHIFT_out,
  input  logic                         OUT_SRAM_READY_in,
  output logic                         OUT_SRAM_WE_out,
  output logic [OUT_SRAM_AWIDTH-1:0]   OUT_SRAM_ADDR_out,
  output logic [NUM_COLS*DWIDTH-1:0]   OUT_SRAM_DATA_out,
  output logic                         BUSY_out,
  output logic                         DONE_out
);

  localparam int RW     = NUM_ROWS_LOG2 + 1;
  localparam int CW     = NUM_COLS_LOG2 + 1;
  localparam int SUM_W  = 2*MAX_TILE_LOG2 + NUM_ROWS_LOG2 + 3;
  localparam int FULL_W = max_int(SUM_W, OUT_SRAM_AWIDTH);

  localparam logic [RW-1:0] ROWS_MAX = RW'(NUM_ROWS);
  localparam logic [CW-1:0] COLS_MAX = CW'(NUM_COLS);
  localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);

  logic [1:0]                 state;
  logic [RW-1:0]              row_cnt;
  logic [MAX_TILE_LOG2-1:0]   tile_row;
  logic [MAX_TILE_LOG2-1:0]   tile_col;
  logic [MAX_TILE_LOG2:0]     num_tile_cols;
  logic [RW-1:0]              actv_rows;
  logic [CW-1:0]              actv_cols;
  logic                       wr_valid;
  logic [OUT_SRAM_AWIDTH-1:0] wr_addr;
  logic [NUM_COLS*DWIDTH-1:0] wr_data;

  logic                       shift;
  logic                       row_live;
  logic [OUT_SRAM_AWIDTH-1:0] row_addr;
  logic [NUM_COLS*DWIDTH-1:0] masked;

  // A shift is allowed only when the output register is free or draining this cycle.
  assign shift    = (state == ST_DRAIN) && (!wr_valid || OUT_SRAM_READY_in);
  assign row_live = row_cnt < actv_rows;

  // Full-width address, then truncated to the SRAM address width.
  assign row_addr = OUT_SRAM_AWIDTH'(
      (FULL_W'(tile_row) * FULL_W'(NUM_ROWS) + FULL_W'(row_cnt))
      * FULL_W'(num_tile_cols) + FULL_W'(tile_col));

  col_mask #(
    .NUM_COLS      (NUM_COLS),
    .NUM_COLS_LOG2 (NUM_COLS_LOG2),
    .DWIDTH        (DWIDTH)
  ) u_col_mask (
    .data   (PE_ROW_DATA_in),
    .count  (actv_cols),
    .masked (masked)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= ST_IDLE;
      row_cnt       <= '0;
      tile_row      <= '0;
      tile_col      <= '0;
      num_tile_cols <= '0;
      actv_rows     <= '0;
      actv_cols     <= '0;
      wr_valid      <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START_in) begin
            tile_row      <= TILE_ROW_ID_in;
            tile_col      <= TILE_COL_ID_in;
            num_tile_cols <= NUM_TILE_COLS_in;
            actv_rows     <= (ACTV_ROWS_in > ROWS_MAX) ? ROWS_MAX : ACTV_ROWS_in;
            actv_cols     <= (ACTV_COLS_in > COLS_MAX) ? COLS_MAX : ACTV_COLS_in;
            row_cnt       <= '0;
            state         <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (shift) begin
            row_cnt <= row_cnt + 1'b1;
            if (row_live) begin
              wr_valid <= 1'b1;
              wr_addr  <= row_addr;
              wr_data  <= masked;
            end else begin
              // shift implies the register was empty or its write was accepted
              wr_valid <= 1'b0;
            end
            if (row_cnt == LAST_ROW) state <= ST_WAIT_WR;
          end
        end
        ST_WAIT_WR: begin
          if (!wr_valid || OUT_SRAM_READY_in) begin
            wr_valid <= 1'b0;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign PE_SHIFT_out      = shift;
  assign OUT_SRAM_WE_out   = wr_valid;
  assign OUT_SRAM_ADDR_out = wr_addr;
  assign OUT_SRAM_DATA_out = wr_data;
  assign BUSY_out          = (state != ST_IDLE);
  assign DONE_out          = (state == ST_DONE);

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: a per-tile list of expected SRAM writes is
// built from the tile config and checked write-by-write as the DUT drains.
module tb_psum_drain;

  localparam int NR = 32;
  localparam int NC = 32;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [4:0]    trow = '0;
  logic [4:0]    tcol = '0;
  logic [5:0]    ntc = '0;
  logic [5:0]    arows = '0;
  logic [5:0]    acols = '0;
  logic [NC*DW-1:0] pe_data;
  logic          shift;
  logic          ready = 1'b1;
  logic          we;
  logic [AW-1:0] addr;
  logic [NC*DW-1:0] wdata;
  logic          busy;
  logic          done;

  always #5 CLK = ~CLK;

  psum_drain dut (
    .CLK               (CLK),
    .RST               (RST),
    .START_in          (start),
    .TILE_ROW_ID_in    (trow),
    .TILE_COL_ID_in    (tcol),
    .NUM_TILE_COLS_in  (ntc),
    .ACTV_ROWS_in      (arows),
    .ACTV_COLS_in      (acols),
    .PE_ROW_DATA_in    (pe_data),
    .PE_SHIFT_out      (shift),
    .OUT_SRAM_READY_in (ready),
    .OUT_SRAM_WE_out   (we),
    .OUT_SRAM_ADDR_out (addr),
    .OUT_SRAM_DATA_out (wdata),
    .BUSY_out          (busy),
    .DONE_out          (done)
  );

  typedef struct {
    logic [AW-1:0]    addr;
    logic [NC*DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int acc_cnt = 0;
  int shift_cnt = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int stall_cycles = 0;
  int pe_idx = 0;
  int pe_base = 0;
  logic [7:0] tag = '0;
  bit stall_en = 1'b0;
  int stall_at = 9;
  int stall_len = 4;
  int stall_cnt = 0;
  bit prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [NC*DW-1:0] prev_data = '0;

  function automatic logic [NC*DW-1:0] gen_row(input logic [7:0] tg, input int r);
    logic [NC*DW-1:0] v;
    for (int c = 0; c < NC; c++) v[c*DW +: DW] = {tg, 8'(r), 8'(c), 8'h5A};
    return v;
  endfunction

  // The array presents rows in order; each shift exposes the next one.
  assign pe_data = gen_row(tag, pe_idx - pe_base);

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (shift) pe_idx <= pe_idx + 1;
  end

  always @(posedge CLK) begin
    #1;
    if (stall_en && we && acc_cnt == stall_at && stall_cnt < stall_len) begin
      ready = 1'b0;
      stall_cnt++;
    end else begin
      ready = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [NC*DW-1:0] act,
                          input logic [NC*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      int c;
      bad++;
      for (c = 0; c < NC; c++) if (act[c*DW +: DW] !== exp[c*DW +: DW]) break;
      if (c >= NC) c = 0;
      $display("FAIL %s col=%0d act=%h exp=%h", name, c, act[c*DW +: DW], exp[c*DW +: DW]);
    end
  endtask

  // Expected writes of one tile, straight from the address/mask rules.
  task automatic build_model(input int tr, input int tc, input int n, input int ar,
                             input int ac, input logic [7:0] tg);
    int rows;
    int cols;
    wr_t e;
    rows = (ar > NR) ? NR : ar;
    cols = (ac > NC) ? NC : ac;
    exp_q.delete();
    for (int r = 0; r < rows; r++) begin
      e.addr = AW'(((tr * NR + r) * n + tc) % (1 << AW));
      e.data = gen_row(tg, r);
      for (int c = cols; c < NC; c++) e.data[c*DW +: DW] = '0;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_tile(input int tr, input int tc, input int n, input int ar,
                            input int ac, input logic [7:0] tg);
    acc_cnt = 0; shift_cnt = 0; done_cnt = 0; done_cyc = -1;
    stall_cycles = 0; stall_cnt = 0;
    @(posedge CLK); #1;
    tag = tg;
    pe_base = pe_idx;
    trow = 5'(tr); tcol = 5'(tc); ntc = 6'(n); arows = 6'(ar); acols = 6'(ac);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic finish_tile(input string name, input int exp_writes, input int exp_cycles);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      @(posedge CLK); #2;
      n++;
    end
    if (done_cnt == 0) begin
      total++; bad++;
      $display("FAIL %s_timeout done_pulses=0 required=1", name);
    end
    @(posedge CLK); #2;
    @(posedge CLK); #2;
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_done_cycle"}, done_cyc, exp_cycles);
    chk({name, "_shifts"}, shift_cnt, NR);
    chk({name, "_writes"}, acc_cnt, exp_writes);
    chk({name, "_leftover"}, exp_q.size(), 0);
    chk({name, "_busy_after"}, busy, 0);
    chk({name, "_done_after"}, done, 0);
  endtask

  always @(negedge CLK) begin
    wr_t e;
    if (RST) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_we", we, 1);
        chk("hold_addr", addr, prev_addr);
        chk_data("hold_data", wdata, prev_data);
      end
      if (we && ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write addr=%0d required=none", addr);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", addr, e.addr);
          chk_data("wr_data", wdata, e.data);
        end
      end
      if (we && !ready) begin
        chk("stall_no_shift", shift, 0);
        stall_cycles++;
      end
      if (shift) shift_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc - start_cyc;
        chk("busy_in_done", busy, 1);
      end
      prev_stall = we && !ready;
      prev_addr  = addr;
      prev_data  = wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_shift", shift, 0);
    chk("rst_we", we, 0);
    chk("rst_addr", addr, 0);
    chk_data("rst_data", wdata, '0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    RST = 1'b0;

    // full tile, ids (1,2), 3 tile columns
    build_model(1, 2, 3, 32, 32, 8'h01);
    chk("model_full_first_addr", exp_q[0].addr, 98);
    chk("model_full_last_addr", exp_q[31].addr, 191);
    chk("model_full_r31c31", exp_q[31].data[31*DW +: DW], 32'h011F1F5A);
    start_tile(1, 2, 3, 32, 32, 8'h01);
    finish_tile("full", 32, 34);

    // partial tile 5 rows x 3 cols
    build_model(0, 0, 1, 5, 3, 8'h02);
    chk("model_part_size", exp_q.size(), 5);
    chk("model_part_last_addr", exp_q[4].addr, 4);
    chk("model_part_r0c0", exp_q[0].data[31:0], 32'h0200005A);
    chk("model_part_c3_zero", exp_q[0].data[3*DW +: DW], 0);
    start_tile(0, 0, 1, 5, 3, 8'h02);
    finish_tile("partial", 5, 34);

    // backpressure on the 10th write, addresses wrap past 1023
    build_model(6, 3, 5, 32, 32, 8'h03);
    chk("model_bp_wrap_addr", exp_q[31].addr, 94);
    stall_en = 1'b1; stall_at = 9; stall_len = 4;
    start_tile(6, 3, 5, 32, 32, 8'h03);
    finish_tile("backpressure", 32, 38);
    chk("bp_stall_cycles", stall_cycles, 4);
    stall_en = 1'b0;

    // no active rows
    build_model(1, 1, 2, 0, 32, 8'h04);
    start_tile(1, 1, 2, 0, 32, 8'h04);
    finish_tile("rows0", 0, 34);

    // no active columns
    build_model(0, 1, 2, 3, 0, 8'h05);
    chk_data("model_cols0_zero", exp_q[0].data, '0);
    start_tile(0, 1, 2, 3, 0, 8'h05);
    finish_tile("cols0", 3, 34);

    // counts above the array size are clamped
    build_model(0, 0, 1, 40, 50, 8'h06);
    chk("model_clamp_size", exp_q.size(), 32);
    start_tile(0, 0, 1, 40, 50, 8'h06);
    finish_tile("clamp", 32, 34);

    // START during DRAIN with different config
    build_model(3, 0, 5, 32, 16, 8'h07);
    start_tile(3, 0, 5, 32, 16, 8'h07);
    repeat (5) @(posedge CLK);
    #1;
    trow = 5'd7; tcol = 5'd4; ntc = 6'd9; arows = 6'd2; acols = 6'd1;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    finish_tile("start_in_drain", 32, 34);

    // reset after the 7th accepted write
    build_model(2, 1, 4, 32, 32, 8'h08);
    start_tile(2, 1, 4, 32, 32, 8'h08);
    n = 0;
    while (acc_cnt < 7 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("rst_mid_seven_writes", acc_cnt, 7);
    RST = 1'b1;
    exp_q.delete();
    @(posedge CLK); #2;
    chk("rst_mid_shift", shift, 0);
    chk("rst_mid_we", we, 0);
    chk("rst_mid_addr", addr, 0);
    chk_data("rst_mid_data", wdata, '0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    RST = 1'b0;
    repeat (40) @(posedge CLK);
    #2;
    chk("rst_mid_no_done", done_cnt, 0);
    chk("rst_mid_no_writes", acc_cnt, 7);

    build_model(1, 2, 3, 32, 32, 8'h09);
    start_tile(1, 2, 3, 32, 32, 8'h09);
    finish_tile("after_rst", 32, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
